// File: rtl/ahb_bm_decode_param.sv
// Slave-interface decode stage: routes one input port onto NUM_MI output stages
// or an internal two-cycle ERROR default slave, and muxes the data-phase response back.
module ahb_bm_decode_param #(
  parameter int              NUM_MI  = 3,
  parameter int              DW      = 32,
  parameter int              RUW     = 32,
  parameter logic [8*22-1:0] MI_BASE = {8{22'h0}},
  parameter logic [8*22-1:0] MI_MASK = {8{22'h0}},
  parameter logic [7:0]      MI_EN   = 8'h07,
  parameter int              CNT_W   = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HREADYS,
  input  logic                  sel_dec,
  input  logic [21:0]           decode_addr_dec,
  input  logic [1:0]            trans_dec,
  input  logic [NUM_MI-1:0]     active_mi,
  input  logic [NUM_MI-1:0]     readyout_mi,
  input  logic [2*NUM_MI-1:0]   resp_mi,
  input  logic [DW*NUM_MI-1:0]  rdata_mi,
  input  logic [RUW*NUM_MI-1:0] ruser_mi,
  input  logic                  unmapped_clr,
  output logic [NUM_MI-1:0]     sel_mi,
  output logic                  active_dec,
  output logic                  HREADYOUTS,
  output logic [1:0]            HRESPS,
  output logic [DW-1:0]         HRDATAS,
  output logic [RUW-1:0]        HRUSERS,
  output logic [CNT_W-1:0]      unmapped_cnt
);

  localparam int             PW = $clog2(NUM_MI + 1);
  localparam logic [PW-1:0]  DS = PW'(NUM_MI);

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

  ds_state_t        ds_state_reg;
  logic             ds_ready_reg;
  logic             ds_err_reg;
  logic [PW-1:0]    data_port_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [NUM_MI-1:0] hit;
  logic [NUM_MI-1:0] keep;
  logic [PW-1:0]     addr_port;
  logic              ds_accept;
  logic              trans_idle;

  assign trans_idle = (trans_dec == 2'b00);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MI; gi++) begin : g_port
      assign hit[gi]    = ((decode_addr_dec & MI_MASK[22*gi +: 22]) == MI_BASE[22*gi +: 22])
                          & MI_EN[gi];
      assign keep[gi]   = (data_port_reg == PW'(gi)) & trans_idle;
      assign sel_mi[gi] = sel_dec & (addr_port == PW'(gi));
    end
  endgenerate

  // Scan from the top down so the lowest qualifying index wins overlaps.
  always_comb begin
    addr_port = DS;
    for (int i = NUM_MI - 1; i >= 0; i--) begin
      if (hit[i] | keep[i]) addr_port = PW'(i);
    end
  end

  always_comb begin
    active_dec = 1'b1;
    for (int i = 0; i < NUM_MI; i++) begin
      if (addr_port == PW'(i)) active_dec = active_mi[i];
    end
  end

  always_comb begin
    HREADYOUTS = ds_ready_reg;
    HRESPS     = ds_err_reg ? 2'b01 : 2'b00;
    HRDATAS    = '0;
    HRUSERS    = '0;
    for (int i = 0; i < NUM_MI; i++) begin
      if (data_port_reg == PW'(i)) begin
        HREADYOUTS = readyout_mi[i];
        HRESPS     = resp_mi[2*i +: 2];
        HRDATAS    = rdata_mi[DW*i +: DW];
        HRUSERS    = ruser_mi[RUW*i +: RUW];
      end
    end
  end

  assign ds_accept = sel_dec & (addr_port == DS) & HREADYS & trans_dec[1];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      data_port_reg <= '0;
    end else if (HREADYS) begin
      data_port_reg <= addr_port;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ds_state_reg <= DS_IDLE;
      ds_ready_reg <= 1'b1;
      ds_err_reg   <= 1'b0;
    end else begin
      case (ds_state_reg)
        DS_IDLE: begin
          if (ds_accept) begin
            ds_state_reg <= DS_ERR1;
            ds_ready_reg <= 1'b0;
            ds_err_reg   <= 1'b1;
          end
        end
        DS_ERR1: begin
          ds_state_reg <= DS_ERR2;
          ds_ready_reg <= 1'b1;
          ds_err_reg   <= 1'b1;
        end
        DS_ERR2: begin
          if (ds_accept) begin
            ds_state_reg <= DS_ERR1;
            ds_ready_reg <= 1'b0;
            ds_err_reg   <= 1'b1;
          end else begin
            ds_state_reg <= DS_IDLE;
            ds_ready_reg <= 1'b1;
            ds_err_reg   <= 1'b0;
          end
        end
        default: begin
          ds_state_reg <= DS_IDLE;
          ds_ready_reg <= 1'b1;
          ds_err_reg   <= 1'b0;
        end
      endcase
    end
  end

  // Counts entries into ERR1; ERR1 itself always advances, so it never counts.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_reg <= '0;
    end else if (unmapped_clr) begin
      cnt_reg <= '0;
    end else if (ds_accept && (ds_state_reg != DS_ERR1) && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign unmapped_cnt = cnt_reg;

endmodule

// File: tb/tb_ahb_bm_decode_param.sv
// Directed bench: a 3-port/32b decoder (8b counter so saturation is reachable)
// plus an 8-port/64b build for the region walk.
module tb_ahb_bm_decode_param;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- 3-port DUT ----------------
  logic        hreadys, sel_dec, unmapped_clr;
  logic [21:0] addr;
  logic [1:0]  trans;
  logic [2:0]  active_mi, readyout_mi, sel_mi;
  logic [5:0]  resp_mi;
  logic [95:0] rdata_mi;
  logic [11:0] ruser_mi;
  logic        active_dec, hreadyouts;
  logic [1:0]  hresps;
  logic [31:0] hrdatas;
  logic [3:0]  hrusers;
  logic [7:0]  cnt;

  ahb_bm_decode_param #(
    .NUM_MI(3), .DW(32), .RUW(4),
    .MI_BASE({{5{22'h0}}, 22'h200000, 22'h100000, 22'h000000}),
    .MI_MASK({8{22'h300000}}),
    .MI_EN(8'h07), .CNT_W(8)
  ) dut (
    .HCLK(clk), .HRESETn(rst_n), .HREADYS(hreadys), .sel_dec(sel_dec),
    .decode_addr_dec(addr), .trans_dec(trans), .active_mi(active_mi),
    .readyout_mi(readyout_mi), .resp_mi(resp_mi), .rdata_mi(rdata_mi),
    .ruser_mi(ruser_mi), .unmapped_clr(unmapped_clr), .sel_mi(sel_mi),
    .active_dec(active_dec), .HREADYOUTS(hreadyouts), .HRESPS(hresps),
    .HRDATAS(hrdatas), .HRUSERS(hrusers), .unmapped_cnt(cnt)
  );

  // ---------------- 8-port DUT ----------------
  logic         sel8;
  logic [21:0]  addr8;
  logic [1:0]   trans8;
  logic [7:0]   sel8_mi, ruser8_out;
  logic [511:0] rdata8_mi;
  logic [63:0]  ruser8_mi;
  logic         act8, rdy8;
  logic [1:0]   resp8;
  logic [63:0]  rdata8;
  logic [15:0]  cnt8;

  ahb_bm_decode_param #(
    .NUM_MI(8), .DW(64), .RUW(8),
    .MI_BASE({22'h380000, 22'h300000, 22'h280000, 22'h200000,
              22'h180000, 22'h100000, 22'h080000, 22'h000000}),
    .MI_MASK({8{22'h380000}}),
    .MI_EN(8'hFF), .CNT_W(16)
  ) dut8 (
    .HCLK(clk), .HRESETn(rst_n), .HREADYS(1'b1), .sel_dec(sel8),
    .decode_addr_dec(addr8), .trans_dec(trans8), .active_mi(8'hFF),
    .readyout_mi(8'hFF), .resp_mi(16'h0), .rdata_mi(rdata8_mi),
    .ruser_mi(ruser8_mi), .unmapped_clr(1'b0), .sel_mi(sel8_mi),
    .active_dec(act8), .HREADYOUTS(rdy8), .HRESPS(resp8),
    .HRDATAS(rdata8), .HRUSERS(ruser8_out), .unmapped_cnt(cnt8)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [21:0] a, input logic [1:0] t, input logic hr);
    sel_dec = s;
    addr    = a;
    trans   = t;
    hreadys = hr;
  endtask

  localparam logic [21:0] A0 = 22'h000004;
  localparam logic [21:0] A1 = 22'h100000;  // 0x4000_0010
  localparam logic [21:0] A2 = 22'h200000;  // 0x8000_0000
  localparam logic [21:0] AU = 22'h300000;  // 0xC000_0000, unmapped
  localparam logic [1:0]  T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10;

  typedef struct {
    logic        s;
    logic [21:0] a;
    logic [1:0]  t;
    logic        hr;
    logic [2:0]  e_sel;
    logic        e_act;
    logic        e_rdy;
    logic [1:0]  e_resp;
    logic [31:0] e_rdata;
    logic [3:0]  e_ruser;
  } vec_t;

  vec_t vecs[9];

  initial begin
    // readyout: port2 stalls; resp: port2 returns ERROR; active: port1 inactive
    active_mi    = 3'b101;
    readyout_mi  = 3'b011;
    resp_mi      = {2'b01, 2'b00, 2'b00};
    rdata_mi     = {32'hCCCC_2222, 32'hBBBB_1111, 32'hAAAA_0000};
    ruser_mi     = {4'h3, 4'h2, 4'h1};
    unmapped_clr = 1'b0;
    drive(1'b0, AU, T_IDLE, 1'b1);
    sel8 = 1'b0; addr8 = '0; trans8 = T_IDLE;
    for (int i = 0; i < 8; i++) begin
      rdata8_mi[64*i +: 64] = {32'hD000_0000 + 32'(i), 32'h0E00_0000 + 32'(i)};
      ruser8_mi[8*i +: 8]   = 8'(i + 16);
    end

    vecs[0] = '{1'b1, A1, T_NSEQ, 1'b1, 3'b010, 1'b0, 1'b1, 2'b00, 32'hBBBB_1111, 4'h2};
    vecs[1] = '{1'b1, A2, T_NSEQ, 1'b1, 3'b100, 1'b1, 1'b0, 2'b01, 32'hCCCC_2222, 4'h3};
    vecs[2] = '{1'b1, AU, T_IDLE, 1'b1, 3'b100, 1'b1, 1'b0, 2'b01, 32'hCCCC_2222, 4'h3};
    vecs[3] = '{1'b1, A0, T_NSEQ, 1'b1, 3'b001, 1'b1, 1'b1, 2'b00, 32'hAAAA_0000, 4'h1};
    vecs[4] = '{1'b0, A1, T_NSEQ, 1'b1, 3'b000, 1'b0, 1'b1, 2'b00, 32'hBBBB_1111, 4'h2};
    vecs[5] = '{1'b1, A2, T_NSEQ, 1'b0, 3'b100, 1'b1, 1'b1, 2'b00, 32'hBBBB_1111, 4'h2};
    vecs[6] = '{1'b1, AU, T_BUSY, 1'b1, 3'b000, 1'b1, 1'b1, 2'b00, 32'h0,         4'h0};
    vecs[7] = '{1'b1, AU, T_IDLE, 1'b1, 3'b000, 1'b1, 1'b1, 2'b00, 32'h0,         4'h0};
    vecs[8] = '{1'b1, A0, T_NSEQ, 1'b1, 3'b001, 1'b1, 1'b1, 2'b00, 32'hAAAA_0000, 4'h1};

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sel", 64'(sel_mi), 64'h0);
    chk("rst_ready", 64'(hreadyouts), 64'(readyout_mi[0]));
    chk("rst_resp", 64'(hresps), 64'h0);
    chk("rst_rdata", 64'(hrdatas), 64'hAAAA_0000);
    chk("rst_cnt", 64'(cnt), 64'h0);
    $display("reset: sel=%b ready=%b resp=%b cnt=%0d", sel_mi, hreadyouts, hresps, cnt);
    rst_n = 1'b1;
    edge1();

    // Table-driven decode and data-phase mux
    for (int v = 0; v < 9; v++) begin
      drive(vecs[v].s, vecs[v].a, vecs[v].t, vecs[v].hr);
      #1;
      chk($sformatf("v%0d_sel", v), 64'(sel_mi), 64'(vecs[v].e_sel));
      chk($sformatf("v%0d_active", v), 64'(active_dec), 64'(vecs[v].e_act));
      edge1();
      chk($sformatf("v%0d_ready", v), 64'(hreadyouts), 64'(vecs[v].e_rdy));
      chk($sformatf("v%0d_resp", v), 64'(hresps), 64'(vecs[v].e_resp));
      chk($sformatf("v%0d_rdata", v), 64'(hrdatas), 64'(vecs[v].e_rdata));
      chk($sformatf("v%0d_ruser", v), 64'(hrusers), 64'(vecs[v].e_ruser));
      $display("vec %0d: addr=%h trans=%b sel_mi=%b ready=%b resp=%b rdata=%h",
               v, vecs[v].a, vecs[v].t, sel_mi, hreadyouts, hresps, hrdatas);
    end

    // Single unmapped NONSEQ: two-cycle ERROR
    drive(1'b1, AU, T_NSEQ, 1'b1);
    edge1();
    chk("ds_err1_ready", 64'(hreadyouts), 64'h0);
    chk("ds_err1_resp", 64'(hresps), 64'h1);
    chk("ds_err1_rdata", 64'(hrdatas), 64'h0);
    chk("ds_err1_cnt", 64'(cnt), 64'h1);
    drive(1'b0, AU, T_IDLE, 1'b0);
    edge1();
    chk("ds_err2_ready", 64'(hreadyouts), 64'h1);
    chk("ds_err2_resp", 64'(hresps), 64'h1);
    hreadys = 1'b1;
    edge1();
    chk("ds_idle_resp", 64'(hresps), 64'h0);
    chk("ds_idle_cnt", 64'(cnt), 64'h1);
    $display("unmapped single: cnt=%0d", cnt);

    // Back-to-back unmapped: ERR2 goes straight to ERR1
    drive(1'b1, AU, T_NSEQ, 1'b1);
    edge1();
    chk("b2b_ready0", 64'(hreadyouts), 64'h0);
    hreadys = 1'b0;
    edge1();
    chk("b2b_ready1", 64'(hreadyouts), 64'h1);
    chk("b2b_resp1", 64'(hresps), 64'h1);
    hreadys = 1'b1;
    edge1();
    chk("b2b_ready2", 64'(hreadyouts), 64'h0);
    hreadys = 1'b0;
    edge1();
    chk("b2b_ready3", 64'(hreadyouts), 64'h1);
    drive(1'b0, AU, T_IDLE, 1'b1);
    edge1();
    chk("b2b_cnt", 64'(cnt), 64'h3);
    chk("b2b_idle_resp", 64'(hresps), 64'h0);
    $display("unmapped back-to-back: cnt=%0d", cnt);

    // Saturation, then clear against a simultaneous accept
    for (int k = 0; k < 260; k++) begin
      drive(1'b1, AU, T_NSEQ, 1'b1);
      edge1();
      hreadys = 1'b0;
      edge1();
    end
    chk("sat_cnt", 64'(cnt), 64'hFF);
    drive(1'b1, AU, T_NSEQ, 1'b1);
    edge1();
    hreadys = 1'b0;
    edge1();
    chk("sat_hold", 64'(cnt), 64'hFF);
    hreadys = 1'b1;
    unmapped_clr = 1'b1;
    edge1();
    chk("clr_cnt", 64'(cnt), 64'h0);
    chk("clr_ready", 64'(hreadyouts), 64'h0);
    unmapped_clr = 1'b0;
    hreadys = 1'b0;
    edge1();
    chk("clr_after", 64'(cnt), 64'h0);
    $display("saturation/clear: cnt=%0d", cnt);

    // Asynchronous reset during ERR1
    hreadys = 1'b1;
    edge1();
    chk("pre_rst_ready", 64'(hreadyouts), 64'h0);
    chk("pre_rst_cnt", 64'(cnt), 64'h1);
    drive(1'b0, AU, T_IDLE, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 64'(hreadyouts), 64'(readyout_mi[0]));
    chk("arst_resp", 64'(hresps), 64'h0);
    chk("arst_rdata", 64'(hrdatas), 64'hAAAA_0000);
    chk("arst_cnt", 64'(cnt), 64'h0);
    chk("arst_sel", 64'(sel_mi), 64'h0);
    $display("async reset in ERR1: ready=%b cnt=%0d", hreadyouts, cnt);
    @(negedge clk);
    rst_n = 1'b1;
    edge1();
    chk("post_rst_rdata", 64'(hrdatas), 64'hAAAA_0000);

    // 8-port, 64-bit region walk
    for (int i = 0; i < 8; i++) begin
      sel8 = 1'b1; addr8 = 22'(i) << 19; trans8 = T_NSEQ;
      #1;
      chk($sformatf("w8_sel%0d", i), 64'(sel8_mi), 64'(8'h01 << i));
      edge1();
      chk($sformatf("w8_rdata%0d", i), rdata8, {32'hD000_0000 + 32'(i), 32'h0E00_0000 + 32'(i)});
      chk($sformatf("w8_ruser%0d", i), 64'(ruser8_out), 64'(i + 16));
      $display("walk8 %0d: sel_mi=%b rdata=%h", i, sel8_mi, rdata8);
    end
    sel8 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
